// File: rtl/issue_unit_pkg.sv
// Shared definitions for the issue arbiter.
// Unit id constants (also the cdb_owner encoding), default unit latencies,
// and the layout of one CDB reservation slot entry.
package issue_unit_pkg;

    localparam int NUM_UNITS = 4;

    localparam logic [1:0] UNIT_INT  = 2'd0;
    localparam logic [1:0] UNIT_LDST = 2'd1;
    localparam logic [1:0] UNIT_MUL  = 2'd2;
    localparam logic [1:0] UNIT_DIV  = 2'd3;

    localparam int DEF_LAT_INT  = 1;
    localparam int DEF_LAT_LDST = 2;
    localparam int DEF_LAT_MUL  = 4;
    localparam int DEF_LAT_DIV  = 6;

    localparam int SLOT_ID_W    = 2;
    localparam int SLOT_ENTRY_W = SLOT_ID_W + 1;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_ID_W-1:0] id;
    } slot_entry_t;

endpackage

// File: rtl/cdb_slot_reg.sv
// CDB reservation shift register.
// Entry k holds the reservation for the CDB k cycles from now. Every clock
// the entries move one step toward entry 0 and the top entry is refilled
// empty; an optional write places {1,id} at wr_idx (post-shift position).
// Ports:
//   clk, srst          - clock, synchronous active-high reset (clears all)
//   wr_en/wr_idx/wr_id - reservation write
//   rd_idx[NRD]        - indices whose valid bit is looked up
//   rd_valid[NRD]      - valid bit of entry rd_idx[i]
//   head_valid/head_id - entry 0, i.e. the CDB owner this cycle
module cdb_slot_reg
    import issue_unit_pkg::*;
#(
    parameter int DEPTH = 7,
    parameter int NRD   = 4,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [SLOT_ID_W-1:0] wr_id,
    input  logic [IDX_W-1:0]     rd_idx [NRD],
    output logic [NRD-1:0]       rd_valid,
    output logic                 head_valid,
    output logic [SLOT_ID_W-1:0] head_id
);

    slot_entry_t slot_reg [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic wr_hit;
            assign wr_hit = wr_en && (wr_idx == IDX_W'(gi));

            if (gi == DEPTH - 1) begin : g_top
                // Nothing shifts into the top entry; it only takes a write.
                always_ff @(posedge clk) begin
                    if (srst) begin
                        slot_reg[gi] <= '0;
                    end else if (wr_hit) begin
                        slot_reg[gi] <= '{valid: 1'b1, id: wr_id};
                    end else begin
                        slot_reg[gi] <= '0;
                    end
                end
            end else begin : g_mid
                always_ff @(posedge clk) begin
                    if (srst) begin
                        slot_reg[gi] <= '0;
                    end else if (wr_hit) begin
                        slot_reg[gi] <= '{valid: 1'b1, id: wr_id};
                    end else begin
                        slot_reg[gi] <= slot_reg[gi+1];
                    end
                end
            end
        end

        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            assign rd_valid[gi] = slot_reg[rd_idx[gi]].valid;
        end
    endgenerate

    assign head_valid = slot_reg[0].valid;
    assign head_id    = slot_reg[0].id;

endmodule

// File: rtl/issue_unit.sv
// Issue arbiter for the four execution queues (int, ldst, mul, div).
// Each cycle grants at most one ready queue head whose CDB result slot is
// still free, reserves that slot, and presents the current CDB owner.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   issue*_ready            - queue head ready (int, ld, mul, div)
//   issue*_done             - queue head accepted this cycle (combinational)
//   cdb_owner/_valid        - unit whose result is on the CDB this cycle
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int LAT_INT  = DEF_LAT_INT,
    parameter int LAT_LDST = DEF_LAT_LDST,
    parameter int LAT_MUL  = DEF_LAT_MUL,
    parameter int LAT_DIV  = DEF_LAT_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issueint_ready,
    output logic       issueint_done,
    input  logic       issueld_ready,
    output logic       issueld_done,
    input  logic       issuemul_ready,
    output logic       issuemul_done,
    input  logic       issuediv_ready,
    output logic       issuediv_done,
    output logic [1:0] cdb_owner,
    output logic       cdb_owner_valid
);

    localparam int DEPTH = LAT_DIV + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LAT_DIV + 1);

    // Indexed by unit id.
    localparam int LAT_TAB [NUM_UNITS] = '{LAT_INT, LAT_LDST, LAT_MUL, LAT_DIV};

    logic [IDX_W-1:0]     look_idx [NUM_UNITS];
    logic [NUM_UNITS-1:0] slot_taken;
    logic [NUM_UNITS-1:0] ready_vec;
    logic [NUM_UNITS-1:0] elig;
    logic [NUM_UNITS-1:0] grant;
    logic [IDX_W-1:0]     wr_idx;
    logic [SLOT_ID_W-1:0] wr_id;
    logic                 lru_reg;
    logic [CNT_W-1:0]     div_busy_reg;
    logic                 div_idle;

    assign ready_vec = {issuediv_ready, issuemul_ready, issueld_ready, issueint_ready};
    assign div_idle  = (div_busy_reg == '0);

    // A unit with latency L must find slot[L] free now: that entry becomes
    // slot[L-1] at the edge, which is where its reservation is written.
    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            assign look_idx[gi] = IDX_W'(LAT_TAB[gi]);
            if (gi == int'(UNIT_DIV)) begin : g_div
                assign elig[gi] = ready_vec[gi] & ~slot_taken[gi] & div_idle;
            end else begin : g_other
                assign elig[gi] = ready_vec[gi] & ~slot_taken[gi];
            end
        end
    endgenerate

    // Fixed priority div > mul > {int, ldst}; int/ldst tie broken by LRU.
    always_comb begin
        grant = '0;
        if (!reset) begin
            if (elig[UNIT_DIV]) begin
                grant[UNIT_DIV] = 1'b1;
            end else if (elig[UNIT_MUL]) begin
                grant[UNIT_MUL] = 1'b1;
            end else if (elig[UNIT_INT] && elig[UNIT_LDST]) begin
                if (lru_reg) begin
                    grant[UNIT_LDST] = 1'b1;
                end else begin
                    grant[UNIT_INT] = 1'b1;
                end
            end else if (elig[UNIT_INT]) begin
                grant[UNIT_INT] = 1'b1;
            end else if (elig[UNIT_LDST]) begin
                grant[UNIT_LDST] = 1'b1;
            end
        end
    end

    always_comb begin
        wr_idx = '0;
        wr_id  = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (grant[u]) begin
                wr_idx = IDX_W'(LAT_TAB[u] - 1);
                wr_id  = SLOT_ID_W'(u);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lru_reg <= 1'b0;
        end else if (grant[UNIT_INT]) begin
            lru_reg <= 1'b1;
        end else if (grant[UNIT_LDST]) begin
            lru_reg <= 1'b0;
        end
    end

    // The divider is not pipelined: hold off the next divide until the
    // current one has had LAT_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_busy_reg <= '0;
        end else if (grant[UNIT_DIV]) begin
            div_busy_reg <= CNT_W'(LAT_DIV - 1);
        end else if (!div_idle) begin
            div_busy_reg <= div_busy_reg - CNT_W'(1);
        end
    end

    cdb_slot_reg #(
        .DEPTH (DEPTH),
        .NRD   (NUM_UNITS)
    ) u_slots (
        .clk        (clk),
        .srst       (reset),
        .wr_en      (|grant),
        .wr_idx     (wr_idx),
        .wr_id      (wr_id),
        .rd_idx     (look_idx),
        .rd_valid   (slot_taken),
        .head_valid (cdb_owner_valid),
        .head_id    (cdb_owner)
    );

    assign issueint_done = grant[UNIT_INT];
    assign issueld_done  = grant[UNIT_LDST];
    assign issuemul_done = grant[UNIT_MUL];
    assign issuediv_done = grant[UNIT_DIV];

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed scenarios followed by random readiness and
// occasional resets, every cycle compared with a reference model that keeps
// CDB bookings as a map from absolute cycle number to owning unit.
module tb_issue_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       int_r = 1'b0, ld_r = 1'b0, mul_r = 1'b0, div_r = 1'b0;
    logic       int_d, ld_d, mul_d, div_d;
    logic [1:0] cdb_owner;
    logic       cdb_owner_valid;

    always #5 clk = ~clk;

    issue_unit #(
        .LAT_INT  (1),
        .LAT_LDST (2),
        .LAT_MUL  (4),
        .LAT_DIV  (6)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .issueint_ready  (int_r),
        .issueint_done   (int_d),
        .issueld_ready   (ld_r),
        .issueld_done    (ld_d),
        .issuemul_ready  (mul_r),
        .issuemul_done   (mul_d),
        .issuediv_ready  (div_r),
        .issuediv_done   (div_d),
        .cdb_owner       (cdb_owner),
        .cdb_owner_valid (cdb_owner_valid)
    );

    localparam int LAT [4] = '{1, 2, 4, 6};

    int n_checks = 0;
    int n_fail   = 0;
    int now      = 0;

    // Reference model state.
    int sched [int];      // cycle -> unit whose result occupies the CDB then
    int div_free_at = 0;  // earliest cycle a new divide may issue
    bit lru = 1'b0;

    logic [3:0] last_done;
    logic       last_valid;
    logic [1:0] last_owner;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, now, obs, want);
        end
    endtask

    // One clock of stimulus; rdy bits are {div, mul, ldst, int}.
    task automatic cycle(input bit rst, input logic [3:0] rdy);
        logic [3:0] want_done;
        logic [3:0] obs_done;
        bit   [3:0] elig;
        int         win;
        @(negedge clk);
        reset = rst;
        int_r = rdy[0];
        ld_r  = rdy[1];
        mul_r = rdy[2];
        div_r = rdy[3];
        #2;
        want_done = '0;
        elig      = '0;
        win       = -1;
        if (!rst) begin
            for (int u = 0; u < 4; u++) begin
                elig[u] = rdy[u] && !sched.exists(now + LAT[u]) && (u != 3 || now >= div_free_at);
            end
            if (elig[3])                 win = 3;
            else if (elig[2])            win = 2;
            else if (elig[0] && elig[1]) win = lru ? 1 : 0;
            else if (elig[0])            win = 0;
            else if (elig[1])            win = 1;
            if (win >= 0) want_done[win] = 1'b1;
        end
        obs_done = {div_d, mul_d, ld_d, int_d};
        check("done", obs_done, want_done);
        check("cdb_valid", {3'b000, cdb_owner_valid}, sched.exists(now) ? 4'd1 : 4'd0);
        check("cdb_owner", {2'b00, cdb_owner}, sched.exists(now) ? 4'(sched[now]) : 4'd0);
        last_done  = obs_done;
        last_valid = cdb_owner_valid;
        last_owner = cdb_owner;
        $display("cyc %0d rst %b rdy %b done %b cdb %b/%0d", now, rst, rdy, obs_done,
                 cdb_owner_valid, cdb_owner);
        if (rst) begin
            sched.delete();
            div_free_at = 0;
            lru = 1'b0;
        end else if (win >= 0) begin
            sched[now + LAT[win]] = win;
            if (win == 3) div_free_at = now + LAT[3];
            if (win == 0) lru = 1'b1;
            if (win == 1) lru = 1'b0;
        end
        now++;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state, then integer queue ready continuously.
        cycle(0, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 4'b0001);
            check("int_every_cycle", last_done, 4'b0001);
            if (i > 0) check("int_owner_valid", {3'b000, last_valid}, 4'd1);
        end

        // Int and ldst competing; int goes first after reset.
        cycle(1, 4'b0000);
        cycle(0, 4'b0011);
        check("int_first", last_done, 4'b0001);
        for (int i = 0; i < 6; i++) cycle(0, 4'b0011);

        // Mul booking blocks a later int issue.
        cycle(1, 4'b0000);
        cycle(0, 4'b0100);
        cycle(0, 4'b0000);
        cycle(0, 4'b0000);
        cycle(0, 4'b0001);
        check("int_blocked", last_done, 4'b0000);
        cycle(0, 4'b0001);
        check("int_after_mul", last_done, 4'b0001);
        check("mul_owner", {1'b0, last_valid, last_owner}, 4'b0110);
        cycle(0, 4'b0000);
        check("int_owner", {1'b0, last_valid, last_owner}, 4'b0100);

        // Divider throughput with multiplies filling the gap.
        cycle(1, 4'b0000);
        for (int c = 0; c <= 12; c++) begin
            cycle(0, (c >= 1 && c <= 5) ? 4'b1100 : 4'b1000);
            check("div_spacing", {3'b000, last_done[3]}, (c % 6 == 0) ? 4'd1 : 4'd0);
            if (c == 6 || c == 12) check("div_owner", {1'b0, last_valid, last_owner}, 4'b0111);
        end

        // All four ready at once.
        cycle(1, 4'b0000);
        cycle(0, 4'b1111);
        check("all_div", last_done, 4'b1000);
        cycle(0, 4'b1111);
        check("all_mul", last_done, 4'b0100);
        cycle(0, 4'b1111);
        check("all_int", last_done, 4'b0001);
        for (int i = 0; i < 4; i++) cycle(0, 4'b1111);

        // Reset with div and mul in flight.
        cycle(1, 4'b0000);
        cycle(0, 4'b1000);
        cycle(0, 4'b0100);
        cycle(0, 4'b0000);
        cycle(1, 4'b1111);
        check("reset_no_done", last_done, 4'b0000);
        cycle(0, 4'b1000);
        check("div_after_reset", last_done, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 4'b0000);
            check("dropped_inflight", {3'b000, last_valid}, 4'd0);
        end

        // Random readiness with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 39) == 0, 4'($urandom));
        end
        for (int i = 0; i < 8; i++) cycle(0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
